gpu_cmd_fetcher: RTL
====================

Name: gpu_cmd_fetcher

Overview:
- Bus-mastering command-list DMA that sits directly upstream of the GPU core's command slave.
- Reads a list of (register, value) command entries from SDRAM over an Avalon read master and replays each entry as one write into the GPU core's 4-bit-address command port.
- Respects the core's wait_request back-pressure, so the CPU no longer has to push every command word itself.

Parameters:
- FIFO_DEPTH, 16: read-data buffer depth in 32-bit words. Power of 2, minimum 4.
- MAX_PENDING, 8: maximum accepted-but-unreturned SDRAM reads. Must be ≤ FIFO_DEPTH.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- csr_address  in  2  CPU control register select
- csr_read  in  1  CPU read strobe; csr_readdata is valid combinationally in the same cycle
- csr_write  in  1  CPU write strobe
- csr_writedata  in  32  CPU write data
- csr_readdata  out  32  CPU read data
- rd_address  out  32  SDRAM byte address
- rd_read  out  1  SDRAM read request
- rd_waitrequest  in  1  SDRAM stall
- rd_readdata  in  32  SDRAM read data
- rd_readdatavalid  in  1  SDRAM read data valid (pipelined reads)
- gpu_address  out  4  command register address to the GPU core
- gpu_write  out  1  command write strobe
- gpu_writedata  out  32  command data
- gpu_waitrequest  in  1  GPU core command buffer full
- irq  out  1  completion interrupt (only with the optional feature)

Behaviour:
- Reset: clk and resetn are as already decided (reset resetn, asynchronous, active-low; clock clk). All registered outputs reset to 0: rd_read, rd_address, gpu_write, gpu_address, gpu_writedata, irq. BASE=0, COUNT=0, busy=0, done=0, PROGRESS=0, FIFO empty, pending=0. FSM resets to IDLE.
- Command list format: each entry is 2 words at consecutive addresses.
  - Word0 (header): bits[3:0] = gpu_address; bits[31:4] ignored.
  - Word1: gpu_writedata.
- CSR map:
  - 0 BASE: read/write; bits[1:0] forced to 0.
  - 1 COUNT: read/write; bits[15:0] = number of entries; upper bits read 0.
  - 2 CTRL: write bit0=go, bit1=abort, bit2=clear done. Read: bit0=busy, bit1=done (sticky).
  - 3 PROGRESS: read-only; number of entries accepted by the GPU core since the last go.
  - Writes to BASE/COUNT while busy are ignored.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE + go: latch the read pointer from BASE, words_left = 2*COUNT, clear PROGRESS and done, go to RUN, busy=1.
  - IDLE + go with COUNT=0: no bus activity; done=1 on the next cycle; stay in IDLE.
  - go while busy is ignored.
- Fetch side (RUN):
  - Assert rd_read when words_left>0 and (pending + fifo_used) < FIFO_DEPTH and pending < MAX_PENDING.
  - rd_address and rd_read are held stable while rd_waitrequest=1.
  - On acceptance (rd_read && !rd_waitrequest): address += 4, words_left -= 1, pending += 1.
  - rd_readdatavalid pushes rd_readdata into the FIFO and decrements pending. A same-cycle accept and return leaves pending unchanged.
  - The FIFO never overflows: this is guaranteed by the issue condition. Reaching overflow is an assertion failure.
- Issue side:
  - Pop the header word, then the data word (as soon as each is present).
  - The cycle after the data word is popped, gpu_write=1 with gpu_address/gpu_writedata registered.
  - These are held while gpu_waitrequest=1. When gpu_write && !gpu_waitrequest: gpu_write drops next cycle unless the next entry is already assembled (back-to-back supported), and PROGRESS += 1.
  - Throughput: 1 entry per 2 cycles when the FIFO is fed.
- Completion: when PROGRESS == COUNT, go to IDLE, busy=0, done=1.
- Abort:
  - In RUN: stop issuing reads. If rd_read is currently stalled, the request is held until accepted, then go to DRAIN.
  - An in-flight gpu_write completes normally. No new gpu writes start.
  - DRAIN: discard returning data until pending==0, flush the FIFO, then go to IDLE, busy=0, done=1.
  - Abort in IDLE is ignored.
- Simultaneous go + abort in IDLE: go wins; abort is ignored.

Optional Feature:
- Macro: GPU_CMD_FETCH_IRQ_EN.
- Defined:
  - irq is a registered level, set on the same edge that sets done.
  - Cleared by CTRL bit2 or by go.
  - CSR 2 bit8 = irq enable; irq = flag & enable; enable resets to 0.
- Undefined: irq tied to 0; CTRL bit8 reads 0.

Test Plan:
- Basic: BASE=0x1000, COUNT=3, memory {0x1,0xF800, 0x2,0x12345, 0x8,0x200000}, zero-latency SDRAM, no GPU stall → GPU writes (1,0xF800),(2,0x12345),(8,0x200000) in order; rd_address 0x1000..0x1014; done=1; PROGRESS=3.
- Back-pressure: gpu_waitrequest high for 20 cycles on entry 2 → entry held stable; reads stop once pending+fifo_used=16; no data lost; completion follows.
- SDRAM latency: readdatavalid 10 cycles after accept, rd_waitrequest toggling → pending never exceeds 8; address held during stall; output identical to the basic case.
- COUNT=0 go → no rd_read; done=1 one cycle later; busy never set.
- Abort mid-run with COUNT=100, abort after PROGRESS=5 with 6 reads pending → the 6 returns are discarded; PROGRESS ≤ 6; IDLE with FIFO empty; a new go then runs a full list correctly.
- Reset asserted mid-run → all outputs 0 immediately; after release, CSR reads BASE=0, COUNT=0, busy=0.

Source files
------------

// File: rtl/gpu_cmd_fetcher.sv
// Command-list DMA: reads (reg,value) pairs from SDRAM and replays them as GPU command writes.
// Define GPU_CMD_FETCH_IRQ_EN to build the completion interrupt.
module gpu_cmd_fetcher #(
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [31:0] rd_address,
  output logic        rd_read,
  input  logic        rd_waitrequest,
  input  logic [31:0] rd_readdata,
  input  logic        rd_readdatavalid,
  output logic [3:0]  gpu_address,
  output logic        gpu_write,
  output logic [31:0] gpu_writedata,
  input  logic        gpu_waitrequest,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nx;
  logic [31:0]   base;
  logic [15:0]   count, progress;
  logic          done, abort_pend, hdr_valid, irq_en_rd;
  logic [3:0]    hdr;
  logic [16:0]   words_left, wl_nx;
  logic [PW-1:0] pending, pend_nx;
  logic [AW:0]   wp, rp, used, used_nx;
  logic [AW+1:0] occ_nx;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [31:0]   fifo_head;
  logic          wr_ctrl, go, abort, clr_done;
  logic          accept, stalled, aborting, issue_en;
  logic          push, pop_hdr, pop_dat, pop, out_free, gpu_acc;
  logic          run_done, drain_done, done_set, can_issue;
  logic          unused_ok;

  assign unused_ok = csr_read;

  assign wr_ctrl  = csr_write && csr_address == 2'd2;
  assign go       = wr_ctrl && csr_writedata[0] && state == IDLE;
  assign abort    = wr_ctrl && csr_writedata[1];
  assign clr_done = wr_ctrl && csr_writedata[2];

  assign accept     = rd_read && !rd_waitrequest;
  assign stalled    = rd_read && rd_waitrequest;
  assign aborting   = state == RUN && (abort || abort_pend);
  assign issue_en   = state == RUN && !aborting;
  assign run_done   = state == RUN && progress == count;
  assign drain_done = state == DRAIN && pending == '0 && !gpu_write;
  assign done_set   = (go && count == '0) || run_done || drain_done;

  assign used      = wp - rp;
  assign fifo_head = mem[rp[AW-1:0]];
  assign push      = rd_readdatavalid && issue_en;
  assign out_free  = !gpu_write || !gpu_waitrequest;
  assign pop_hdr   = issue_en && !hdr_valid && used != '0;
  assign pop_dat   = issue_en && hdr_valid && used != '0 && out_free;
  assign pop       = pop_hdr || pop_dat;
  assign gpu_acc   = gpu_write && !gpu_waitrequest;

  // Issue decision looks at next-cycle occupancy so every read owns a FIFO slot.
  assign wl_nx     = words_left - 17'(accept);
  assign pend_nx   = pending + PW'(accept) - PW'(rd_readdatavalid);
  assign used_nx   = used + (AW+1)'(push) - (AW+1)'(pop);
  assign occ_nx    = (AW+2)'(pend_nx) + (AW+2)'(used_nx);
  assign can_issue = issue_en && wl_nx != '0 &&
                     occ_nx < (AW+2)'(FIFO_DEPTH) &&
                     pend_nx < PW'(MAX_PENDING);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go && count != '0) state_nx = RUN;
      RUN:     if (run_done) state_nx = IDLE;
               else if (aborting && !stalled) state_nx = DRAIN;
      DRAIN:   if (drain_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= rd_readdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      base          <= '0;
      count         <= '0;
      progress      <= '0;
      done          <= 1'b0;
      abort_pend    <= 1'b0;
      words_left    <= '0;
      pending       <= '0;
      wp            <= '0;
      rp            <= '0;
      hdr_valid     <= 1'b0;
      hdr           <= '0;
      rd_read       <= 1'b0;
      rd_address    <= '0;
      gpu_write     <= 1'b0;
      gpu_address   <= '0;
      gpu_writedata <= '0;
    end else begin
      state      <= state_nx;
      pending    <= pend_nx;
      words_left <= wl_nx;
      abort_pend <= aborting && stalled && !run_done;
      if (csr_write && csr_address == 2'd0 && state == IDLE)
        base <= {csr_writedata[31:2], 2'b00};
      if (csr_write && csr_address == 2'd1 && state == IDLE)
        count <= csr_writedata[15:0];
      if (!stalled) rd_read <= can_issue;
      if (accept) rd_address <= rd_address + 32'd4;
      if (gpu_acc) progress <= progress + 16'd1;
      if (clr_done) done <= 1'b0;
      if (go) begin
        done       <= 1'b0;
        progress   <= '0;
        words_left <= {count, 1'b0};
        rd_address <= base;
      end
      if (done_set) done <= 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (pop_hdr) begin
        hdr       <= fifo_head[3:0];
        hdr_valid <= 1'b1;
      end
      if (pop_dat) begin
        gpu_write     <= 1'b1;
        gpu_address   <= hdr;
        gpu_writedata <= fifo_head;
        hdr_valid     <= 1'b0;
      end else if (gpu_acc) begin
        gpu_write <= 1'b0;
      end
      if (drain_done) begin
        rp        <= wp;
        hdr_valid <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!resetn)
    !(push && used == DEPTH));

`ifdef GPU_CMD_FETCH_IRQ_EN
  logic irq_flag, irq_en;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_flag <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= csr_writedata[8];
      if (done_set) irq_flag <= 1'b1;
      else if (clr_done || go) irq_flag <= 1'b0;
    end
  end
  assign irq       = irq_flag && irq_en;
  assign irq_en_rd = irq_en;
`else
  assign irq       = 1'b0;
  assign irq_en_rd = 1'b0;
`endif

  always_comb begin
    csr_readdata = '0;
    unique case (csr_address)
      2'd0:    csr_readdata = base;
      2'd1:    csr_readdata = {16'b0, count};
      2'd2:    csr_readdata = {23'b0, irq_en_rd, 6'b0, done,
                               state != IDLE};
      default: csr_readdata = {16'b0, progress};
    endcase
  end
endmodule
